keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl.sv | 154 +++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Turns debounced keypad events into strobes for an external digit shift
// register, captures two operands from it, and sequences one add.
//
// Ports
//   clk, reset       system clock, asynchronous active-high reset
//   key_valid        one-cycle key event; key_digit is the hex digit, and
//                    key_clr / key_enter / key_bksp qualify it as a command
//                    (priority clr > enter > bksp > digit)
//   sr_q             current contents of the external shift register
//   sr_trig          one-cycle shift strobe
//   sr_dir           0 = shift left (append), 1 = shift right (backspace)
//   sr_in            digit presented to the shift register
//   sr_reset_n       active-low clear to the shift register
//   op_a, op_b       committed operands
//   add_start        one-cycle add request; add_done is the adder's reply
//   digit_cnt        digits currently held in the shift register
//   state_o          current state encoding
//
// Handshake: key_valid and add_done are single-cycle pulses with no ready
// back-pressure; a pulse that arrives in a state that does not accept it is
// dropped. sr_trig and add_start are single-cycle pulses decoded from state.
module keypad_entry_ctrl #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4,
  localparam int OPW   = DIGITS * WIDTH,
  localparam int CW    = $clog2(DIGITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [WIDTH-1:0] key_digit,
  input  logic             key_clr,
  input  logic             key_bksp,
  input  logic             key_enter,
  input  logic [OPW-1:0]   sr_q,
  output logic             sr_trig,
  output logic             sr_dir,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_reset_n,
  output logic [OPW-1:0]   op_a,
  output logic [OPW-1:0]   op_b,
  output logic             add_start,
  input  logic             add_done,
  output logic [CW-1:0]    digit_cnt,
  output logic [2:0]       state_o
);

  localparam logic [2:0] S_ENTER_A = 3'd0;
  localparam logic [2:0] S_ENTER_B = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CLEAR   = 3'd3;
  localparam logic [2:0] S_START   = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_SHOW    = 3'd6;

  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  logic [2:0]    state;
  logic [2:0]    ret_state;   // where SHIFT / CLEAR go next
  logic          pend_shift;  // SHOW digit: CLEAR is followed by a SHIFT
  logic          up;          // set on the first clock edge after reset
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_ENTER_A;
      ret_state  <= S_ENTER_A;
      pend_shift <= 1'b0;
      up         <= 1'b0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      sr_in      <= '0;
      sr_dir     <= 1'b0;
    end else begin
      up <= 1'b1;
      case (state)
        S_ENTER_A, S_ENTER_B, S_SHOW: begin
          if (key_valid) begin
            if (key_clr) begin
              state <= S_CLEAR;
              if (state == S_SHOW) begin
                ret_state <= S_ENTER_A;
                op_a      <= '0;
                op_b      <= '0;
              end else begin
                ret_state <= state;
              end
            end else if (key_enter) begin
              if (state == S_ENTER_A) begin
                op_a      <= sr_q;
                state     <= S_CLEAR;
                ret_state <= S_ENTER_B;
              end else if (state == S_ENTER_B) begin
                op_b      <= sr_q;
                state     <= S_CLEAR;
                ret_state <= S_START;
              end
            end else if (key_bksp) begin
              if (state != S_SHOW && cnt != '0) begin
                sr_in     <= '0;
                sr_dir    <= 1'b1;
                state     <= S_SHIFT;
                ret_state <= state;
              end
            end else if (state == S_SHOW) begin
              // A digit in SHOW clears everything and starts a fresh op_a.
              // sr_in/sr_dir are loaded now so they are settled through
              // CLEAR and the following SHIFT.
              op_a       <= '0;
              op_b       <= '0;
              sr_in      <= key_digit;
              sr_dir     <= 1'b0;
              pend_shift <= 1'b1;
              ret_state  <= S_ENTER_A;
              state      <= S_CLEAR;
            end else if (cnt < FULL) begin
              sr_in     <= key_digit;
              sr_dir    <= 1'b0;
              state     <= S_SHIFT;
              ret_state <= state;
            end
          end
        end
        S_SHIFT: begin
          state <= ret_state;
          if (sr_dir) cnt <= cnt - CW'(1);
          else        cnt <= cnt + CW'(1);
        end
        S_CLEAR: begin
          cnt <= '0;
          if (pend_shift) begin
            pend_shift <= 1'b0;
            state      <= S_SHIFT;
          end else begin
            state <= ret_state;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT:  if (add_done) state <= S_SHOW;
        default: state <= S_ENTER_A;
      endcase
    end
  end

  // Strobes are pure state decodes, so they vanish the instant reset hits.
  assign sr_trig    = (state == S_SHIFT);
  assign add_start  = (state == S_START);
  assign sr_reset_n = up && (state != S_CLEAR);
  assign digit_cnt  = cnt;
  assign state_o    = state;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
module tb_keypad_entry_ctrl;
  localparam int DIGITS = 4;
  localparam int WIDTH  = 4;
  localparam int OPW    = 16;

  localparam int P_A = 0, P_B = 1, P_WAIT = 2, P_SHOW = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             key_valid = 1'b0;
  logic [WIDTH-1:0] key_digit = '0;
  logic             key_clr = 1'b0, key_bksp = 1'b0, key_enter = 1'b0;
  logic [OPW-1:0]   sr_q = '0;
  logic             sr_trig, sr_dir, sr_reset_n, add_start;
  logic [WIDTH-1:0] sr_in;
  logic [OPW-1:0]   op_a, op_b;
  logic             add_done = 1'b0;
  logic [2:0]       digit_cnt;
  logic [2:0]       state_o;

  int n_cmp = 0;
  int n_err = 0;

  keypad_entry_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .key_clr(key_clr), .key_bksp(key_bksp), .key_enter(key_enter),
    .sr_q(sr_q), .sr_trig(sr_trig), .sr_dir(sr_dir), .sr_in(sr_in),
    .sr_reset_n(sr_reset_n), .op_a(op_a), .op_b(op_b),
    .add_start(add_start), .add_done(add_done),
    .digit_cnt(digit_cnt), .state_o(state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // External shift register the controller drives.
  always @(posedge clk) begin
    if (!sr_reset_n) sr_q <= '0;
    else if (sr_trig) sr_q <= sr_dir ? (sr_q >> WIDTH) : {sr_q[OPW-WIDTH-1:0], sr_in};
  end

  // reference model: entered digits as a queue, plus phase and operands
  int           dq[$];
  int           phase = P_A;
  logic [15:0]  m_a = '0, m_b = '0;

  function automatic logic [15:0] dq_val();
    int v = 0;
    foreach (dq[i]) v = v * 16 + dq[i];
    return 16'(v);
  endfunction

  function automatic logic [31:0] exp_state();
    case (phase)
      P_A:     return 32'd0;
      P_B:     return 32'd1;
      P_WAIT:  return 32'd5;
      default: return 32'd6;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_key(input bit c, input bit e, input bit b, input int d,
                           output int e_trig, output int e_low, output int e_add,
                           output int e_dir, output int e_in);
    e_trig = 0; e_low = 0; e_add = 0; e_dir = 0; e_in = 0;
    if (phase == P_A || phase == P_B) begin
      if (c) begin
        dq.delete(); e_low = 1;
      end else if (e) begin
        if (phase == P_A) begin m_a = dq_val(); phase = P_B; end
        else begin m_b = dq_val(); phase = P_WAIT; e_add = 1; end
        dq.delete(); e_low = 1;
      end else if (b) begin
        if (dq.size() > 0) begin void'(dq.pop_back()); e_trig = 1; e_dir = 1; end
      end else if (dq.size() < DIGITS) begin
        dq.push_back(d); e_trig = 1; e_in = d;
      end
    end else if (phase == P_SHOW) begin
      if (c || (!e && !b)) begin
        m_a = '0; m_b = '0; dq.delete(); phase = P_A; e_low = 1;
        if (!c) begin dq.push_back(d); e_trig = 1; e_in = d; end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, 32'(state_o), exp_state());
    chk({tag, ".cnt"}, 32'(digit_cnt), 32'(dq.size()));
    chk({tag, ".op_a"}, 32'(op_a), 32'(m_a));
    chk({tag, ".op_b"}, 32'(op_b), 32'(m_b));
    chk({tag, ".sr_q"}, 32'(sr_q), 32'(dq_val()));
  endtask

  // driver: one key event, then a fixed observation window
  task automatic press(input string tag, input bit c, input bit e, input bit b, input int d);
    int e_trig, e_low, e_add, e_dir, e_in;
    int n_trig = 0, n_low = 0, n_add = 0, overlap = 0;
    int low_idx = -10, add_idx = -20, t_dir = 0, t_in = 0;
    model_key(c, e, b, d, e_trig, e_low, e_add, e_dir, e_in);
    @(negedge clk);
    key_valid = 1'b1; key_clr = c; key_enter = e; key_bksp = b; key_digit = 4'(d);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      key_valid = 1'b0; key_clr = 1'b0; key_enter = 1'b0; key_bksp = 1'b0;
      if (sr_trig) begin n_trig++; t_dir = int'(sr_dir); t_in = int'(sr_in); end
      if (!sr_reset_n) begin n_low++; low_idx = i; end
      if (add_start) begin n_add++; add_idx = i; end
      if (sr_trig && add_start) overlap++;
    end
    chk({tag, ".trig"}, 32'(n_trig), 32'(e_trig));
    chk({tag, ".low"}, 32'(n_low), 32'(e_low));
    chk({tag, ".add"}, 32'(n_add), 32'(e_add));
    chk({tag, ".overlap"}, 32'(overlap), 32'd0);
    if (e_trig != 0) begin
      chk({tag, ".dir"}, 32'(t_dir), 32'(e_dir));
      chk({tag, ".in"}, 32'(t_in), 32'(e_in));
    end
    if (e_add != 0) chk({tag, ".add_after_clear"}, 32'(add_idx), 32'(low_idx + 1));
    check_model(tag);
  endtask

  task automatic pulse_done(input string tag);
    @(negedge clk);
    add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0;
    if (phase == P_WAIT) phase = P_SHOW;
    repeat (2) @(negedge clk);
    check_model(tag);
  endtask

  task automatic check_reset_vals(input string tag, input logic exp_srn);
    chk({tag, ".state"}, 32'(state_o), 32'd0);
    chk({tag, ".cnt"}, 32'(digit_cnt), 32'd0);
    chk({tag, ".op_a"}, 32'(op_a), 32'd0);
    chk({tag, ".op_b"}, 32'(op_b), 32'd0);
    chk({tag, ".trig"}, 32'(sr_trig), 32'd0);
    chk({tag, ".dir"}, 32'(sr_dir), 32'd0);
    chk({tag, ".in"}, 32'(sr_in), 32'd0);
    chk({tag, ".add"}, 32'(add_start), 32'd0);
    chk({tag, ".srn"}, 32'(sr_reset_n), 32'(exp_srn));
  endtask

  task automatic model_reset();
    dq.delete(); phase = P_A; m_a = '0; m_b = '0;
  endtask

  initial begin
    // power-on reset
    reset = 1'b1;
    #1;
    check_reset_vals("por_async", 1'b0);
    repeat (2) @(negedge clk);
    check_reset_vals("por_held", 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("por_release", 1'b1);
    model_reset();

    // backspace with nothing entered is ignored
    press("bksp_empty", 0, 0, 1, 0);

    // five digits, fifth ignored, then commit op_a
    press("d1", 0, 0, 0, 1);
    press("d2", 0, 0, 0, 2);
    press("d3", 0, 0, 0, 3);
    press("d4", 0, 0, 0, 4);
    press("d5_full", 0, 0, 0, 5);
    press("enter_a", 0, 1, 0, 0);
    chk("op_a_1234", 32'(op_a), 32'h1234);

    // A, B, backspace, C, enter on operand B
    press("dA", 0, 0, 0, 10);
    press("dB", 0, 0, 0, 11);
    press("bk", 0, 0, 1, 0);
    press("dC", 0, 0, 0, 12);
    press("enter_b", 0, 1, 0, 0);
    chk("op_b_ac", 32'(op_b), 32'h00AC);

    // keys during WAIT are dropped; stray add_done only counts in WAIT
    press("wait_digit", 0, 0, 0, 7);
    press("wait_bksp", 0, 0, 1, 0);
    pulse_done("done1");

    // digit in SHOW starts a new op_a entry
    press("show_digit", 0, 0, 0, 7);
    press("d9", 0, 0, 0, 9);
    // clear beats enter
    press("clr_enter", 1, 1, 0, 0);

    // randomized key stream against the model
    for (int i = 0; i < 250; i++) begin
      if ((phase == P_WAIT && $urandom_range(0, 1) == 0) || $urandom_range(0, 15) == 0)
        pulse_done("rnd_done");
      else
        press("rnd", $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 4) == 0, int'($urandom_range(0, 15)));
    end

    // steer back to ENTER_A
    for (int i = 0; i < 6 && phase != P_A; i++) begin
      if (phase == P_WAIT) pulse_done("steer_done");
      else press("steer", phase == P_SHOW, phase == P_B, 0, 0);
    end
    chk("steered_to_a", 32'(state_o), 32'd0);

    // full add: 0x3C00 + 0x4000
    press("full_clr", 1, 0, 0, 0);
    press("f3", 0, 0, 0, 3);
    press("fC", 0, 0, 0, 12);
    press("f0a", 0, 0, 0, 0);
    press("f0b", 0, 0, 0, 0);
    press("f_enter_a", 0, 1, 0, 0);
    press("f4", 0, 0, 0, 4);
    press("f0c", 0, 0, 0, 0);
    press("f0d", 0, 0, 0, 0);
    press("f0e", 0, 0, 0, 0);
    press("f_enter_b", 0, 1, 0, 0);
    chk("full_op_a", 32'(op_a), 32'h3C00);
    chk("full_op_b", 32'(op_b), 32'h4000);
    repeat (4) @(negedge clk);
    chk("full_still_wait", 32'(state_o), 32'd5);
    pulse_done("full_done");

    // reset during WAIT, then a late add_done
    press("rw_clr", 1, 0, 0, 0);
    press("rw_d", 0, 0, 0, 6);
    press("rw_enter_a", 0, 1, 0, 0);
    press("rw_enter_b", 0, 1, 0, 0);
    chk("rw_in_wait", 32'(state_o), 32'd5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("rw_async", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_vals("rw_release", 1'b1);
    pulse_done("rw_late_done");
    check_reset_vals("rw_after_done", 1'b1);

    // reset while a shift strobe is high
    press("rs_d", 0, 0, 0, 5);
    @(negedge clk);
    key_valid = 1'b1; key_digit = 4'd8;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    chk("rs_in_shift", 32'(sr_trig), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("rs_async", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("rs_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
